// File: rtl/pulse_trig_pkg.sv
// Shared definitions for the pulse trigger receiver.
// State indices, trigger type codes, FIFO field offsets, saturating increment.
package pulse_trig_pkg;

    localparam int S_IDLE_I     = 0;
    localparam int S_SEND_I     = 1;
    localparam int S_SAMPLE_I   = 2;
    localparam int S_CLASSIFY_I = 3;
    localparam int S_STORE_I    = 4;

    typedef enum logic [4:0] {
        IDLE     = 5'b00001 << S_IDLE_I,
        SEND     = 5'b00001 << S_SEND_I,
        SAMPLE   = 5'b00001 << S_SAMPLE_I,
        CLASSIFY = 5'b00001 << S_CLASSIFY_I,
        STORE    = 5'b00001 << S_STORE_I
    } state_t;

    localparam logic [1:0] TT_LASER = 2'b10;
    localparam logic [1:0] TT_AM    = 2'b01;
    localparam logic [1:0] TT_BOTH  = 2'b11;

    localparam int FD_TS_LSB = 0;

    function automatic int fd_tnum_lsb(int ts_w);
        return ts_w;
    endfunction

    function automatic int fd_type_lsb(int ts_w, int tnum_w);
        return ts_w + tnum_w;
    endfunction

    function automatic logic [31:0] sat_inc(logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/burst_occupancy_tracker.sv
// Per-channel DDR3 burst occupancy: add on trigger, subtract on readout credit.
// Ports: en/add_pulse/credit controls, burst_count/rd_bursts/thres in; full/warning out.
module burst_occupancy_tracker #(
    parameter int BURST_W = 23
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               add_pulse,
    input  logic               credit,
    input  logic [BURST_W-1:0] burst_count,
    input  logic [BURST_W-1:0] rd_bursts,
    input  logic [BURST_W-1:0] thres,
    output logic               full,
    output logic               warning
);

    localparam logic [BURST_W:0] CAP = {1'b1, {BURST_W{1'b0}}};

    logic [BURST_W:0]   stored;
    logic [BURST_W:0]   need;
    logic [BURST_W:0]   add_v;
    logic [BURST_W:0]   sub_v;
    logic [BURST_W:0]   room;
    logic [BURST_W:0]   nxt;
    logic [BURST_W+1:0] sum;
    logic [BURST_W+1:0] diff;

    // Add and credit in the same cycle net out; result floors at 0
    // and never exceeds the DDR3 depth.
    always_comb begin
        need  = {1'b0, burst_count} + (BURST_W+1)'(1);
        add_v = (add_pulse && en) ? need : '0;
        sub_v = credit ? {1'b0, rd_bursts} : '0;
        sum   = {1'b0, stored} + {1'b0, add_v};
        diff  = sum - {1'b0, sub_v};
        room  = CAP - stored;
        if (sum < {1'b0, sub_v})
            nxt = '0;
        else if (diff > {1'b0, CAP})
            nxt = CAP;
        else
            nxt = diff[BURST_W:0];
    end

    assign full    = en && (room < need);
    assign warning = stored > {1'b0, thres};

    always_ff @(posedge clk) begin
        if (reset)
            stored <= '0;
        else
            stored <= nxt;
    end

endmodule

// File: rtl/pulse_trigger_receiver_nch.sv
// Front-panel trigger receiver: pulse, classify, record to FIFO, track DDR3 fill.
// Ports: trigger/chan_en/burst/rd credit in; pulse_trigger, fifo_*, counters out.
// Optional TRIG_HOLDOFF_EN adds holdoff_cycles: IDLE ignores triggers after STORE.
module pulse_trigger_receiver_nch
    import pulse_trig_pkg::*;
#(
    parameter int NCHAN    = 5,
    parameter int BURST_W  = 23,
    parameter int TS_W     = 44,
    parameter int TNUM_W   = 24,
    parameter int HIST_LEN = 4,
    parameter int FIFO_W   = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reset_trig_num,
    input  logic                     reset_trig_timestamp,
    input  logic                     trigger,
    input  logic [NCHAN-1:0]         chan_en,
    input  logic [NCHAN*BURST_W-1:0] burst_count,
    input  logic [BURST_W-1:0]       thres_ddr3_overflow,
    input  logic [NCHAN-1:0]         rd_strobe,
    input  logic [NCHAN*BURST_W-1:0] rd_bursts,
    input  logic                     fifo_ready,
`ifdef TRIG_HOLDOFF_EN
    input  logic [15:0]              holdoff_cycles,
`endif
    output logic                     pulse_trigger,
    output logic [TNUM_W-1:0]        trig_num,
    output logic                     fifo_valid,
    output logic [FIFO_W-1:0]        fifo_data,
    output logic [4:0]               state,
    output logic [31:0]              ddr3_overflow_count,
    output logic [31:0]              missed_trig_count,
    output logic [NCHAN-1:0]         ddr3_overflow_warning
);

    localparam int KW       = $clog2(HIST_LEN);
    localparam int TNUM_LSB = fd_tnum_lsb(TS_W);
    localparam int TYPE_LSB = fd_type_lsb(TS_W, TNUM_W);
    localparam logic [KW-1:0] K_FIRST = KW'(2);
    localparam logic [KW-1:0] K_LAST  = KW'(HIST_LEN - 1);

    state_t              st;
    logic [TS_W-1:0]     ts_cnt;
    logic [TS_W-1:0]     trig_ts;
    logic [TNUM_W-1:0]   rec_num;
    logic [HIST_LEN-1:0] hist;
    logic [KW-1:0]       k;
    logic                trig_prev;
    logic [NCHAN-1:0]    full_v;
    logic                any_full;
    logic                holdoff_active;
    logic                accept;
    logic                ovf_ev;
    logic                missed_ev;
    logic [1:0]          cls;
    logic [FIFO_W-1:0]   word;

    assign state    = st;
    assign any_full = |full_v;

    assign accept = st[S_IDLE_I] && trigger
                    && !holdoff_active && !any_full;
    assign ovf_ev = st[S_IDLE_I] && trigger
                    && !holdoff_active && any_full;
    // Missed counts rising edges only, so a long level counts once.
    assign missed_ev = trigger && !trig_prev
                       && (!st[S_IDLE_I] || holdoff_active);

    always_comb begin
        if (!hist[HIST_LEN-1])
            cls = TT_LASER;
        else if (&hist)
            cls = TT_AM;
        else
            cls = TT_BOTH;
    end

    always_comb begin
        word = '0;
        word[FD_TS_LSB +: TS_W] = trig_ts;
        word[TNUM_LSB +: TNUM_W] = rec_num;
        word[TYPE_LSB +: 2] = cls;
    end

`ifdef TRIG_HOLDOFF_EN
    logic [15:0] hold_cnt;

    assign holdoff_active = (hold_cnt != 16'd0);

    always_ff @(posedge clk) begin
        if (reset)
            hold_cnt <= '0;
        else if (st[S_STORE_I] && fifo_ready)
            hold_cnt <= holdoff_cycles;
        else if (st[S_IDLE_I] && holdoff_active)
            hold_cnt <= hold_cnt - 16'd1;
    end
`else
    assign holdoff_active = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            st                  <= IDLE;
            ts_cnt              <= '0;
            trig_ts             <= '0;
            trig_num            <= '0;
            rec_num             <= '0;
            hist                <= '0;
            k                   <= '0;
            trig_prev           <= 1'b0;
            pulse_trigger       <= 1'b0;
            fifo_valid          <= 1'b0;
            fifo_data           <= '0;
            ddr3_overflow_count <= '0;
            missed_trig_count   <= '0;
        end else begin
            trig_prev     <= trigger;
            pulse_trigger <= 1'b0;
            ts_cnt <= reset_trig_timestamp ? '0 : ts_cnt + TS_W'(1);
            if (missed_ev)
                missed_trig_count <= sat_inc(missed_trig_count);
            if (ovf_ev)
                ddr3_overflow_count <= sat_inc(ddr3_overflow_count);
            unique case (1'b1)
                st[S_IDLE_I]: begin
                    if (accept) begin
                        trig_num      <= trig_num + TNUM_W'(1);
                        rec_num       <= trig_num + TNUM_W'(1);
                        trig_ts       <= ts_cnt;
                        hist          <= HIST_LEN'(1);
                        pulse_trigger <= 1'b1;
                        st            <= SEND;
                    end
                end
                st[S_SEND_I]: begin
                    hist[1] <= trigger;
                    k       <= K_FIRST;
                    st      <= (HIST_LEN > 2) ? SAMPLE : CLASSIFY;
                end
                st[S_SAMPLE_I]: begin
                    hist[k] <= trigger;
                    k       <= k + KW'(1);
                    if (k == K_LAST)
                        st <= CLASSIFY;
                end
                st[S_CLASSIFY_I]: begin
                    fifo_data  <= word;
                    fifo_valid <= 1'b1;
                    st         <= STORE;
                end
                st[S_STORE_I]: begin
                    if (fifo_ready) begin
                        fifo_valid <= 1'b0;
                        st         <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
            // Clears win over a same-cycle accept; rec_num keeps old+1.
            if (reset_trig_num)
                trig_num <= '0;
            if (reset_trig_timestamp)
                trig_ts <= '0;
        end
    end

    for (genvar c = 0; c < NCHAN; c++) begin : g_occ
        burst_occupancy_tracker #(
            .BURST_W(BURST_W)
        ) u_occ (
            .clk        (clk),
            .reset      (reset),
            .en         (chan_en[c]),
            .add_pulse  (pulse_trigger),
            .credit     (rd_strobe[c]),
            .burst_count(burst_count[c*BURST_W +: BURST_W]),
            .rd_bursts  (rd_bursts[c*BURST_W +: BURST_W]),
            .thres      (thres_ddr3_overflow),
            .full       (full_v[c]),
            .warning    (ddr3_overflow_warning[c])
        );
    end

endmodule

// File: tb/tb_pulse_trigger_receiver_nch.sv
// Self-checking bench for pulse_trigger_receiver_nch (default build).
// Directed steps with a scoreboard queue of expected FIFO records.
module tb_pulse_trigger_receiver_nch;

    localparam int NCHAN  = 5;
    localparam int BW     = 4;
    localparam int TS_W   = 44;
    localparam int TNUM_W = 24;
    localparam int HL     = 4;
    localparam int FW     = 128;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  reset_trig_num = 1'b0;
    logic                  reset_trig_timestamp = 1'b0;
    logic                  trigger = 1'b0;
    logic [NCHAN-1:0]      chan_en = '0;
    logic [NCHAN*BW-1:0]   burst_count = '0;
    logic [BW-1:0]         thres_ddr3_overflow = '0;
    logic [NCHAN-1:0]      rd_strobe = '0;
    logic [NCHAN*BW-1:0]   rd_bursts = '0;
    logic                  fifo_ready = 1'b1;
    logic                  pulse_trigger;
    logic [TNUM_W-1:0]     trig_num;
    logic                  fifo_valid;
    logic [FW-1:0]         fifo_data;
    logic [4:0]            state;
    logic [31:0]           ddr3_overflow_count;
    logic [31:0]           missed_trig_count;
    logic [NCHAN-1:0]      ddr3_overflow_warning;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_num = 0;
    logic [FW-1:0] sb[$];
    logic [TS_W-1:0] model_ts;

    always #5 clk = ~clk;

    // Reference timestamp counter
    always @(posedge clk)
        model_ts <= (reset || reset_trig_timestamp) ? '0 : model_ts + 1;

    pulse_trigger_receiver_nch #(
        .NCHAN(NCHAN), .BURST_W(BW), .TS_W(TS_W),
        .TNUM_W(TNUM_W), .HIST_LEN(HL), .FIFO_W(FW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .reset_trig_num       (reset_trig_num),
        .reset_trig_timestamp (reset_trig_timestamp),
        .trigger              (trigger),
        .chan_en              (chan_en),
        .burst_count          (burst_count),
        .thres_ddr3_overflow  (thres_ddr3_overflow),
        .rd_strobe            (rd_strobe),
        .rd_bursts            (rd_bursts),
        .fifo_ready           (fifo_ready),
        .pulse_trigger        (pulse_trigger),
        .trig_num             (trig_num),
        .fifo_valid           (fifo_valid),
        .fifo_data            (fifo_data),
        .state                (state),
        .ddr3_overflow_count  (ddr3_overflow_count),
        .missed_trig_count    (missed_trig_count),
        .ddr3_overflow_warning(ddr3_overflow_warning)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [FW-1:0] obs,
                         input logic [FW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(logic [1:0] t,
                                         logic [TNUM_W-1:0] n,
                                         logic [TS_W-1:0] ts);
        logic [FW-1:0] w;
        w = '0;
        w[43:0]  = ts;
        w[67:44] = n;
        w[69:68] = t;
        return w;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_num = 0;
        sb.delete();
    endtask

    // Drive a 4-cycle trigger pattern starting in IDLE (pat[0] first).
    task automatic fire(input logic [3:0] pat, input logic rtn,
                        input string tag);
        logic [1:0] t;
        if (!pat[3])
            t = 2'b10;
        else if (pat == 4'hF)
            t = 2'b01;
        else
            t = 2'b11;
        sb.push_back(mk(t, TNUM_W'(exp_num + 1), model_ts));
        trigger = pat[0];
        reset_trig_num = rtn;
        tick();
        reset_trig_num = 1'b0;
        check({tag, "_pulse"}, FW'(pulse_trigger), FW'(1));
        exp_num = rtn ? 0 : exp_num + 1;
        check({tag, "_tnum"}, FW'(trig_num), FW'(exp_num));
        for (int i = 1; i < 4; i++) begin
            trigger = pat[i];
            tick();
            if (i == 1)
                check({tag, "_pulse1"}, FW'(pulse_trigger), FW'(0));
        end
        trigger = 1'b0;
    endtask

    task automatic collect(input string tag);
        int n;
        logic [FW-1:0] e;
        n = 0;
        while (!fifo_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, FW'(n), FW'(1));
        e = (sb.size() == 0) ? '1 : sb.pop_front();
        check({tag, "_data"}, fifo_data, e);
    endtask

    task automatic handshake(input string tag);
        fifo_ready = 1'b1;
        tick();
        check({tag, "_vld0"}, FW'(fifo_valid), FW'(0));
        check({tag, "_idle"}, FW'(state), FW'(5'b00001));
        tick();
    endtask

    initial begin
        logic [FW-1:0] held;
        int highs;

        do_reset();
        check("rst_state", FW'(state), FW'(5'b00001));
        check("rst_pulse", FW'(pulse_trigger), FW'(0));
        check("rst_valid", FW'(fifo_valid), FW'(0));
        check("rst_data", fifo_data, '0);
        check("rst_tnum", FW'(trig_num), FW'(0));
        check("rst_ovf", FW'(ddr3_overflow_count), FW'(0));
        check("rst_miss", FW'(missed_trig_count), FW'(0));
        check("rst_warn", FW'(ddr3_overflow_warning), FW'(0));

        fire(4'b1111, 1'b0, "am");
        collect("am");
        handshake("am");

        fire(4'b0001, 1'b0, "laser");
        collect("laser");
        handshake("laser");
        check("laser_miss", FW'(missed_trig_count), FW'(0));

        fire(4'b1001, 1'b0, "both");
        collect("both");
        handshake("both");
        check("both_miss", FW'(missed_trig_count), FW'(1));

        reset_trig_timestamp = 1'b1;
        tick();
        reset_trig_timestamp = 1'b0;
        fire(4'b1111, 1'b1, "rtn");
        collect("rtn");
        handshake("rtn");
        check("rtn_after", FW'(trig_num), FW'(0));

        do_reset();
        fifo_ready = 1'b0;
        fire(4'b1111, 1'b0, "stall");
        collect("stall");
        held = fifo_data;
        for (int i = 0; i < 10; i++) begin
            trigger = (i == 3);
            tick();
            check("stall_vld", FW'(fifo_valid), FW'(1));
            check("stall_data", fifo_data, mk(2'b01, 24'd1, held[43:0]));
        end
        trigger = 1'b0;
        handshake("stall");
        check("stall_miss", FW'(missed_trig_count), FW'(1));

        do_reset();
        chan_en = 5'b00001;
        burst_count = {5{4'd7}};
        thres_ddr3_overflow = 4'd10;
        rd_bursts = {5{4'd8}};
        fire(4'b1111, 1'b0, "ovf1");
        collect("ovf1");
        handshake("ovf1");
        fire(4'b1111, 1'b0, "ovf2");
        collect("ovf2");
        handshake("ovf2");
        check("ovf_warn", FW'(ddr3_overflow_warning), FW'(5'b00001));
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("ovf3_nopulse", FW'(pulse_trigger), FW'(0));
        check("ovf3_cnt", FW'(ddr3_overflow_count), FW'(1));
        tick();
        check("ovf3_idle", FW'(state), FW'(5'b00001));
        check("ovf3_tnum", FW'(trig_num), FW'(2));
        rd_strobe = 5'b00001;
        tick();
        rd_strobe = '0;
        tick();
        check("rd_warn", FW'(ddr3_overflow_warning), FW'(0));
        fire(4'b1111, 1'b0, "ovf4");
        collect("ovf4");
        handshake("ovf4");
        check("ovf4_cnt", FW'(ddr3_overflow_count), FW'(1));
        chan_en = '0;

        do_reset();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        check("mid_sample", FW'(state), FW'(5'b00100));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_idle", FW'(state), FW'(5'b00001));
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            if (fifo_valid)
                highs++;
            tick();
        end
        check("mid_nowrite", FW'(highs), FW'(0));
        check("mid_tnum", FW'(trig_num), FW'(0));
        check("sb_empty", FW'(sb.size()), FW'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
